alu_issue_pipe: RTL

//  Pipelined issue/retire wrapper around the 32-bit ALU (ALU dut: result, carryout, zero, overflow, a, b, control).

---
 rtl/alu_issue_pipe.sv | 183 ++++++++++++++++++
 1 files changed

// File: rtl/alu_issue_pipe.sv
// alu_issue_pipe: issue register -> 32-bit ALU -> output FIFO, plus a sticky
// signed-overflow flag and a wrapping count of retired operations.
//
// Handshakes (both sides): a transfer happens on a rising clk edge where
// valid & ready are both 1. A producer holds its payload stable while valid=1
// and ready=0; ready may depend combinationally on the other side's ready but
// never on the same side's valid.

// 32-bit ALU: add/sub/xor/slt/and/nand/or/nor with carry, zero and signed overflow.
module alu_issue_pipe_alu (
    output logic [31:0] result,
    output logic        carryout,
    output logic        zero,
    output logic        overflow,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic [2:0]  control
);

    logic        is_sub;
    logic [31:0] b_eff;
    logic [32:0] sum;

    // The adder runs for every op; sub and slt use a + ~b + 1, everything else a + b.
    // carryout/overflow always come from the adder, so logic ops report raw adder flags.
    always_comb begin
        is_sub   = (control == 3'b001) || (control == 3'b011);
        b_eff    = is_sub ? ~b : b;
        sum      = {1'b0, a} + {1'b0, b_eff} + {32'd0, is_sub};
        carryout = sum[32];
        overflow = (a[31] == b_eff[31]) && (sum[31] != a[31]);
        result   = '0;
        case (control)
            3'b000:  result = sum[31:0];
            3'b001:  result = sum[31:0];
            3'b010:  result = a ^ b;
            3'b011:  result = {31'd0, sum[31] ^ overflow};
            3'b100:  result = a & b;
            3'b101:  result = ~(a & b);
            3'b110:  result = a | b;
            default: result = ~(a | b);
        endcase
        zero = (result == 32'd0);
    end

endmodule

module alu_issue_pipe #(
    parameter int WIDTH      = 32,
    parameter int FIFO_DEPTH = 2,
    parameter int CNT_W      = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic [2:0]       in_ctrl,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_result,
    output logic [2:0]       out_flags,
    output logic [2:0]       out_ctrl,
    input  logic             clr_sticky,
    output logic             ovf_sticky,
    output logic [CNT_W-1:0] op_count
);

    localparam int PTR_W   = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int FCNT_W  = $clog2(FIFO_DEPTH + 1);
    localparam int ENTRY_W = WIDTH + 6;
    localparam logic [PTR_W-1:0]  LAST_PTR  = PTR_W'(FIFO_DEPTH - 1);
    localparam logic [FCNT_W-1:0] DEPTH_CNT = FCNT_W'(FIFO_DEPTH);

    // Stage-1 issue register
    logic [WIDTH-1:0] s1_a;
    logic [WIDTH-1:0] s1_b;
    logic [2:0]       s1_ctrl;
    logic             s1_valid;

    // ALU outputs
    logic [WIDTH-1:0] alu_result;
    logic             alu_carry;
    logic             alu_zero;
    logic             alu_ovf;

    // Output FIFO
    logic [ENTRY_W-1:0] mem [FIFO_DEPTH];
    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   rd_ptr;
    logic [FCNT_W-1:0]  fifo_cnt;

    logic accept;
    logic push;
    logic pop;
    logic s1_adv;

    // ALU sees only the registered stage-1 operands, never the raw inputs.
    alu_issue_pipe_alu u_alu (
        .result   (alu_result),
        .carryout (alu_carry),
        .zero     (alu_zero),
        .overflow (alu_ovf),
        .a        (s1_a),
        .b        (s1_b),
        .control  (s1_ctrl)
    );

    // Handshake glue: s1 retires when the FIFO has room now or frees a slot this cycle.
    always_comb begin
        out_valid = (fifo_cnt != '0);
        pop       = out_valid & out_ready;
        s1_adv    = s1_valid & ((fifo_cnt < DEPTH_CNT) | pop);
        push      = s1_adv;
        in_ready  = ~s1_valid | s1_adv;
        accept    = in_valid & in_ready;
        {out_result, out_flags, out_ctrl} = mem[rd_ptr];
    end

    // Stage-1 register: load on accept, otherwise empty out when its op retires.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_a     <= '0;
            s1_b     <= '0;
            s1_ctrl  <= '0;
        end else if (accept) begin
            s1_valid <= 1'b1;
            s1_a     <= in_a;
            s1_b     <= in_b;
            s1_ctrl  <= in_ctrl;
        end else if (s1_adv) begin
            s1_valid <= 1'b0;
        end
    end

    // FIFO storage and circular pointers; push+pop when full leaves the count unchanged.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem[i] <= '0;
            end
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            fifo_cnt <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= {alu_result, alu_carry, alu_zero, alu_ovf, s1_ctrl};
                wr_ptr      <= (wr_ptr == LAST_PTR) ? '0 : wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= (rd_ptr == LAST_PTR) ? '0 : rd_ptr + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   fifo_cnt <= fifo_cnt + FCNT_W'(1);
                2'b01:   fifo_cnt <= fifo_cnt - FCNT_W'(1);
                default: fifo_cnt <= fifo_cnt;
            endcase
        end
    end

    // Sticky overflow: only add/sub overflows count, and a set beats a same-cycle clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf_sticky <= 1'b0;
        end else if (push && alu_ovf && (s1_ctrl[2:1] == 2'b00)) begin
            ovf_sticky <= 1'b1;
        end else if (clr_sticky) begin
            ovf_sticky <= 1'b0;
        end
    end

    // Retired-op counter, wraps modulo 2^CNT_W.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_count <= '0;
        end else if (push) begin
            op_count <= op_count + CNT_W'(1);
        end
    end

endmodule
